// File: rtl/game_ctrl.sv
// Round sequencer: runs one puzzle round, scores keypad submissions per area and enforces the countdown.
// All outputs are registered; a submission is judged in the single CHECK cycle after it is accepted.
module game_ctrl #(
    parameter int unsigned   TIME_LIMIT = 300,
    parameter logic [127:0]  TARGETS    = 128'h0F0F_F0F0_3C3C_C3C3_00FF_FF00_AAAA_5555
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        switch,
    input  logic        tick,
    input  logic        submit,
    input  logic [2:0]  area,
    input  logic [15:0] dot,
    output logic        finish,
    output logic        win,
    output logic        timeout,
    output logic [7:0]  solved,
    output logic [3:0]  misses,
    output logic [8:0]  remaining,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] TIME_INIT = 9'(TIME_LIMIT);

    state_t      state_q, state_d;
    logic        finish_q, finish_d;
    logic        win_q, win_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  solved_q, solved_d;
    logic [3:0]  misses_q, misses_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [2:0]  area_lat_q, area_lat_d;
    logic [15:0] dot_lat_q, dot_lat_d;

    logic tick_vld;
    logic expire;
    logic match;

    always_comb begin
        state_d     = state_q;
        finish_d    = finish_q;
        win_d       = win_q;
        timeout_d   = timeout_q;
        solved_d    = solved_q;
        misses_d    = misses_q;
        remaining_d = remaining_q;
        area_lat_d  = area_lat_q;
        dot_lat_d   = dot_lat_q;

        // A tick only counts while running; the countdown stops at zero because expiry ends the round.
        tick_vld = switch && tick && (state_q == PLAY || state_q == CHECK);
        expire   = tick_vld && (remaining_q == 9'd1);
        match    = (dot_lat_q == TARGETS[16*area_lat_q +: 16]);

        if (tick_vld && remaining_q != 9'd0) begin
            remaining_d = remaining_q - 9'd1;
        end

        case (state_q)
            IDLE: begin
                if (switch) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (expire) begin
                    timeout_d = 1'b1;
                    finish_d  = 1'b1;
                    state_d   = DONE;
                end else if (switch && submit) begin
                    area_lat_d = area;
                    dot_lat_d  = dot;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (match) begin
                    solved_d[area_lat_q] = 1'b1;
                end else if (misses_q != 4'd15) begin
                    misses_d = misses_q + 4'd1;
                end
                // Completing the board beats a simultaneous expiry.
                if (solved_d == 8'hFF) begin
                    win_d    = 1'b1;
                    finish_d = 1'b1;
                    state_d  = DONE;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    finish_d  = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = PLAY;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            finish_q    <= 1'b0;
            win_q       <= 1'b0;
            timeout_q   <= 1'b0;
            solved_q    <= 8'd0;
            misses_q    <= 4'd0;
            remaining_q <= TIME_INIT;
            area_lat_q  <= 3'd0;
            dot_lat_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            finish_q    <= finish_d;
            win_q       <= win_d;
            timeout_q   <= timeout_d;
            solved_q    <= solved_d;
            misses_q    <= misses_d;
            remaining_q <= remaining_d;
            area_lat_q  <= area_lat_d;
            dot_lat_q   <= dot_lat_d;
        end
    end

    assign finish    = finish_q;
    assign win       = win_q;
    assign timeout   = timeout_q;
    assign solved    = solved_q;
    assign misses    = misses_q;
    assign remaining = remaining_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a default-limit and a 3-second instance share stimulus and are checked every cycle against a round model.
module tb_game_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        switch = 1'b0;
    logic        tick = 1'b0;
    logic        submit = 1'b0;
    logic [2:0]  area = 3'd0;
    logic [15:0] dot = 16'd0;

    logic        d0_finish, d0_win, d0_timeout;
    logic [7:0]  d0_solved;
    logic [3:0]  d0_misses;
    logic [8:0]  d0_remaining;
    logic [1:0]  d0_state;
    logic        d1_finish, d1_win, d1_timeout;
    logic [7:0]  d1_solved;
    logic [3:0]  d1_misses;
    logic [8:0]  d1_remaining;
    logic [1:0]  d1_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    game_ctrl dut (
        .clock(clock), .reset(reset), .switch(switch), .tick(tick), .submit(submit),
        .area(area), .dot(dot), .finish(d0_finish), .win(d0_win), .timeout(d0_timeout),
        .solved(d0_solved), .misses(d0_misses), .remaining(d0_remaining), .state(d0_state)
    );

    game_ctrl #(.TIME_LIMIT(3)) dut_t (
        .clock(clock), .reset(reset), .switch(switch), .tick(tick), .submit(submit),
        .area(area), .dot(dot), .finish(d1_finish), .win(d1_win), .timeout(d1_timeout),
        .solved(d1_solved), .misses(d1_misses), .remaining(d1_remaining), .state(d1_state)
    );

    // Target per area, written out from the documented table (area 0 is the low word).
    logic [15:0] tgt [8] = '{16'h5555, 16'hAAAA, 16'hFF00, 16'h00FF,
                             16'hC3C3, 16'h3C3C, 16'hF0F0, 16'h0F0F};

    // Round model: phase 0 idle, 1 play, 2 judging, 3 over.
    typedef struct {
        int          phase;
        int          secs;
        logic [7:0]  done_areas;
        int          wrong;
        logic        over;
        logic        won;
        logic        expired;
        int          pend_area;
        logic [15:0] pend_dot;
    } round_t;

    round_t m0, m1;

    function automatic round_t fresh(input int limit);
        round_t r;
        r.phase = 0; r.secs = limit; r.done_areas = 8'd0; r.wrong = 0;
        r.over = 1'b0; r.won = 1'b0; r.expired = 1'b0; r.pend_area = 0; r.pend_dot = 16'd0;
        return r;
    endfunction

    function automatic round_t step(input round_t r, input int limit, input logic rst_n,
                                   input logic sw, input logic tk, input logic sb,
                                   input logic [2:0] ar, input logic [15:0] dt);
        logic counted;
        if (!rst_n) return fresh(limit);
        counted = sw && tk;
        if (r.phase == 0) begin
            if (sw) r.phase = 1;
        end else if (r.phase == 1) begin
            if (sw) begin
                if (tk) begin
                    r.secs = r.secs - 1;
                    if (r.secs == 0) begin
                        r.expired = 1'b1; r.over = 1'b1; r.phase = 3;
                        return r;
                    end
                end
                if (sb) begin
                    r.pend_area = int'(ar); r.pend_dot = dt; r.phase = 2;
                end
            end
        end else if (r.phase == 2) begin
            if (r.pend_dot == tgt[r.pend_area]) r.done_areas[r.pend_area] = 1'b1;
            else if (r.wrong < 15) r.wrong = r.wrong + 1;
            if (counted) r.secs = r.secs - 1;
            if (r.done_areas == 8'hFF) begin
                r.won = 1'b1; r.over = 1'b1; r.phase = 3;
            end else if (counted && r.secs == 0) begin
                r.expired = 1'b1; r.over = 1'b1; r.phase = 3;
            end else begin
                r.phase = 1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("d0_state", int'(d0_state), m0.phase);
        check("d0_remaining", int'(d0_remaining), m0.secs);
        check("d0_solved", int'(d0_solved), int'(m0.done_areas));
        check("d0_misses", int'(d0_misses), m0.wrong);
        check("d0_finish", int'(d0_finish), int'(m0.over));
        check("d0_win", int'(d0_win), int'(m0.won));
        check("d0_timeout", int'(d0_timeout), int'(m0.expired));
        check("d1_state", int'(d1_state), m1.phase);
        check("d1_remaining", int'(d1_remaining), m1.secs);
        check("d1_solved", int'(d1_solved), int'(m1.done_areas));
        check("d1_misses", int'(d1_misses), m1.wrong);
        check("d1_finish", int'(d1_finish), int'(m1.over));
        check("d1_win", int'(d1_win), int'(m1.won));
        check("d1_timeout", int'(d1_timeout), int'(m1.expired));
    endtask

    // One clock: drive, let the edge happen, advance both models, then compare 1 time unit later.
    task automatic cyc(input logic rst_n, input logic sw, input logic tk, input logic sb,
                       input logic [2:0] ar, input logic [15:0] dt);
        reset = rst_n; switch = sw; tick = tk; submit = sb; area = ar; dot = dt;
        @(posedge clock);
        m0 = step(m0, 300, rst_n, sw, tk, sb, ar, dt);
        m1 = step(m1, 3, rst_n, sw, tk, sb, ar, dt);
        #1;
        check_all();
    endtask

    task automatic restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    endtask

    initial begin
        m0 = fresh(300);
        m1 = fresh(3);
        #2;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        check("rst_remaining", int'(d0_remaining), 300);
        check("rst_state", int'(d0_state), 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'h5555);

        // Solve every area in order
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'(i), tgt[i]);
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 16'd0);
        end
        check("solve_all_win", int'(d0_win), 1);
        check("solve_all_misses", int'(d0_misses), 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'd0);

        // Misses saturate, then a wrong-area pattern and the true pattern for area 2
        restart();
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0000);
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0000);
        end
        check("miss_saturate", int'(d0_misses), 15);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h00FF);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'hFF00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0000);
        check("area2_solved", int'(d0_solved), 8'h04);

        // Timeout on the 3-second instance, then frozen
        restart();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
        end
        check("t_timeout", int'(d1_timeout), 1);
        check("t_remaining", int'(d1_remaining), 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h5555);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);

        // Pause ignores ticks and submits; then tick+submit at the last second
        restart();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, (i == 2), 3'd0, 16'h5555);
        check("pause_remaining", int'(d1_remaining), 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 16'hAAAA);
        check("tick_submit_solved", int'(d1_solved), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);

        // Reset while judging
        restart();
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'hC3C3);
        check("pre_rst_state", int'(d0_state), 2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
        check("mid_rst_state", int'(d0_state), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);

        // Randomised rounds
        begin
            logic sw_hold = 1'b1;
            for (int c = 0; c < 4000; c++) begin
                logic rn, sw, tk, sb;
                logic [2:0] ar;
                logic [15:0] dt;
                rn = ($urandom_range(0, 299) != 0);
                if ($urandom_range(0, 29) == 0) sw_hold = ($urandom_range(0, 3) != 0);
                sw = sw_hold;
                if (m0.phase == 2 || m1.phase == 2) sw = 1'b1;
                tk = ($urandom_range(0, 11) == 0);
                sb = ($urandom_range(0, 2) == 0);
                ar = 3'($urandom_range(0, 7));
                dt = ($urandom_range(0, 1) == 0) ? tgt[ar] : 16'($urandom);
                cyc(rn, sw, tk, sb, ar, dt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
